sc_dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (sc_datamem, clocked on ~clock) between the CPU

---
 rtl/sc_arb_pkg.sv | 17 +
 rtl/sc_dmem_arbiter_if.sv | 44 ++++
 rtl/sc_arb_starve_cnt.sv | 30 +++
 rtl/sc_dmem_arbiter.sv | 106 ++++++++++
 tb/tb_sc_dmem_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sc_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter between the CPU and one aux master.
package sc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int STAT_W = 16;

    // Width able to hold 0..max_wait inclusive.
    function automatic int wait_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/sc_dmem_arbiter_if.sv
// Bundle of the CPU, aux and datamem port signals around the arbiter.
interface sc_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          aux_req;
    logic          aux_we;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_ack;
    logic [DW-1:0] aux_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_ack, aux_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    // Requesters plus memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_ack, aux_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/sc_arb_starve_cnt.sv
// Counts cycles the aux master has waited; flags starvation once MAX is reached.
module sc_arb_starve_cnt
    import sc_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic starve
);
    localparam int W = wait_w(MAX);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != MAX_V)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starve = (wait_cnt == MAX_V);

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Arbitrates the single datamem port: CPU by default, aux in idle cycles or when starved.
// Define SC_ARB_STATS_EN to add saturating stall / aux-grant statistic counters.
module sc_dmem_arbiter
    import sc_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                clock,
    input  logic                resetn,
    sc_dmem_arbiter_if.slave    bus
`ifdef SC_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_stall_cnt,
    output logic [STAT_W-1:0]   stat_aux_cnt
`endif
);
    arb_state_t    state, state_nxt;
    logic          aux_grant;
    logic          starve;
    logic          cnt_inc;
    logic          cnt_clr;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    sc_arb_starve_cnt #(.MAX(MAX_WAIT)) u_starve (
        .clock  (clock),
        .resetn (resetn),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .starve (starve)
    );

    // ACK blocks aux for a cycle, so the CPU can never stall twice in a row.
    always_comb begin
        aux_grant = (state != ACK) && bus.aux_req && (!bus.cpu_req || starve);
        cnt_inc   = (state != ACK) && bus.aux_req && !aux_grant;
        cnt_clr   = aux_grant || !bus.aux_req;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aux_grant)        state_nxt = ACK;
                else if (bus.aux_req) state_nxt = WAIT;
            end
            WAIT: begin
                if (aux_grant)        state_nxt = ACK;
                else if (!bus.aux_req) state_nxt = IDLE;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        addr_sel  = aux_grant ? bus.aux_addr  : bus.cpu_addr;
        wdata_sel = aux_grant ? bus.aux_wdata : bus.cpu_wdata;
    end

    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.mem_we    = aux_grant ? bus.aux_we : (bus.cpu_req && bus.cpu_we);
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req && aux_grant;

    // Memory is clocked on ~clock, so mem_rdata is already settled at the next posedge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.aux_ack   <= 1'b0;
            bus.aux_rdata <= '0;
        end else begin
            bus.aux_ack <= aux_grant;
            if (aux_grant) begin
                bus.aux_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef SC_ARB_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_stall_cnt <= '0;
            stat_aux_cnt   <= '0;
        end else begin
            if (bus.cpu_stall && (stat_stall_cnt != {STAT_W{1'b1}})) begin
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
            end
            if (aux_grant && (stat_aux_cnt != {STAT_W{1'b1}})) begin
                stat_aux_cnt <= stat_aux_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Randomized plus directed bench for sc_dmem_arbiter against a cycle-level reference model.
module tb_sc_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    sc_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    logic [31:0] mem [16];
    always @(negedge clock) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

`ifdef SC_ARB_STATS_EN
    logic [15:0] stat_stall_cnt, stat_aux_cnt;
    sc_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(32), .DW(32)) u_dut (
        .clock(clock), .resetn(resetn), .bus(bus.slave),
        .stat_stall_cnt(stat_stall_cnt), .stat_aux_cnt(stat_aux_cnt)
    );
`else
    sc_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(32), .DW(32)) u_dut (
        .clock(clock), .resetn(resetn), .bus(bus.slave)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a memory image, how long aux has waited, whether the
    // previous cycle was an aux transfer, and what aux should see next.
    logic [31:0] ref_mem [16];
    int          waited;
    bit          in_ack;
    bit          exp_ack;
    logic [31:0] exp_aux_rdata;
    bit          last_stall;
    int          m_stall_cnt, m_aux_cnt;
    bit          obs_stall;
    logic [31:0] obs_crd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        waited = 0; in_ack = 0; exp_ack = 0; exp_aux_rdata = '0;
        last_stall = 0; m_stall_cnt = 0; m_aux_cnt = 0;
    endtask

    // Drive one cycle of inputs (called at posedge+1), check, advance the model.
    task automatic step(input bit c_req, input bit c_we, input logic [31:0] c_addr,
                        input logic [31:0] c_wdata, input bit a_req, input bit a_we,
                        input logic [31:0] a_addr, input logic [31:0] a_wdata);
        bit          grant, stall, ewe;
        logic [31:0] ea, ew, erd;
        bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wdata;
        bus.aux_req = a_req; bus.aux_we = a_we; bus.aux_addr = a_addr; bus.aux_wdata = a_wdata;
        #3;
        grant = a_req && !in_ack && (!c_req || waited >= MAX_WAIT);
        stall = c_req && grant;
        ea    = grant ? a_addr : c_addr;
        ew    = grant ? a_wdata : c_wdata;
        ewe   = grant ? a_we : (c_req && c_we);
        erd   = ref_mem[ea[5:2]];
        obs_stall = bus.cpu_stall;
        obs_crd   = bus.cpu_rdata;
        chk("aux_ack", {31'd0, bus.aux_ack}, {31'd0, exp_ack});
        chk("aux_rdata", bus.aux_rdata, exp_aux_rdata);
        chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, stall});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, ewe});
        if (c_req || grant) chk("mem_addr", bus.mem_addr, ea);
        if (ewe) chk("mem_wdata", bus.mem_wdata, ew);
        if (c_req && !c_we && !stall) chk("cpu_rdata", bus.cpu_rdata, erd);
        if (last_stall) chk("no_double_stall", {31'd0, bus.cpu_stall}, 32'd0);
        if (ewe) ref_mem[ea[5:2]] = ew;
        exp_ack = grant;
        if (grant) exp_aux_rdata = ewe ? ew : erd;
        if (stall && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
        if (grant && m_aux_cnt < 16'hFFFF) m_aux_cnt++;
        if (grant || !a_req) waited = 0;
        else if (!in_ack && waited < MAX_WAIT) waited++;
        in_ack     = grant;
        last_stall = stall;
        @(posedge clock); #1;
`ifdef SC_ARB_STATS_EN
        chk("stat_stall_cnt", {16'd0, stat_stall_cnt}, 32'(m_stall_cnt));
        chk("stat_aux_cnt", {16'd0, stat_aux_cnt}, 32'(m_aux_cnt));
`endif
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        bit          a_act;
        bit          a_we_r, c_req_r, c_we_r;
        logic [31:0] a_addr_r, a_wd_r, c_addr_r, c_wd_r;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        model_reset();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_aux_ack", {31'd0, bus.aux_ack}, 32'd0);
        chk("rst_aux_rdata", bus.aux_rdata, 32'd0);
        resetn = 1'b1;

        // Preload memory through CPU stores; word 4 (0x10) holds 0xCAFE0001.
        for (int i = 0; i < 16; i++)
            step(1, 1, 32'(i) << 2, (i == 4) ? 32'hCAFE0001 : $urandom, 0, 0, 32'h0, 32'h0);

        // Aux read with CPU idle: ack next cycle with memory data.
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
        chk("t1_ack", {31'd0, bus.aux_ack}, 32'd1);
        chk("t1_rdata", bus.aux_rdata, 32'hCAFE0001);
        idle();

        // CPU busy every cycle: aux forced in on the fifth cycle, single stall.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
            chk("t2_stall", {31'd0, obs_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t2_ack", {31'd0, bus.aux_ack}, 32'd1);
        idle();

        // aux_req held through the ACK cycle: no grant there, CPU load passes.
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h14, 32'h0);
        step(1, 0, 32'h10, 32'h0, 1, 0, 32'h18, 32'h0);
        chk("t3_stall", {31'd0, obs_stall}, 32'd0);
        chk("t3_crd", obs_crd, 32'hCAFE0001);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h18, 32'h0);
        idle();
        idle();

        // Forced aux write collides with CPU store to the same word; CPU retry wins.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 32'h20, 32'hA5, (i <= 4), 1, 32'h20, 32'h5A);
            chk("t4_stall", {31'd0, obs_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t4_mem", mem[8], 32'hA5);
        idle();

        // Reset asserted mid-wait: no ack, counter restarts from zero.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
        resetn = 1'b0;
        #2;
        chk("t5_ack", {31'd0, bus.aux_ack}, 32'd0);
        chk("t5_rdata", bus.aux_rdata, 32'd0);
        @(posedge clock); #1;
        chk("t5_ack_hold", {31'd0, bus.aux_ack}, 32'd0);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
            chk("t5_stall", {31'd0, obs_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        idle();

        // Randomized traffic; stalled CPU accesses are reissued unchanged.
        a_act = 0; a_we_r = 0; a_addr_r = '0; a_wd_r = '0;
        c_req_r = 0; c_we_r = 0; c_addr_r = '0; c_wd_r = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                c_req_r  = ($urandom_range(0, 3) != 0);
                c_we_r   = 1'($urandom_range(0, 1));
                c_addr_r = 32'($urandom_range(0, 15)) << 2;
                c_wd_r   = $urandom;
            end
            if (a_act && exp_ack) a_act = 0;
            else if (a_act && $urandom_range(0, 15) == 0) a_act = 0;
            if (!a_act && $urandom_range(0, 2) == 0) begin
                a_act    = 1;
                a_we_r   = 1'($urandom_range(0, 1));
                a_addr_r = 32'($urandom_range(0, 15)) << 2;
                a_wd_r   = $urandom;
            end
            step(c_req_r, c_we_r, c_addr_r, c_wd_r, a_act, a_we_r, a_addr_r, a_wd_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
